// File: rtl/ped_btn_conditioner.sv
// Crosswalk button front end: synchronizes and debounces the raw button, latches a
// crossing request until the controller serves it, and divides clk down to the slow tick.
module ped_btn_conditioner #(
  parameter int TP         = 1,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16,
  parameter int TICK_DIV   = 50000000,
  parameter int TICK_W     = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       serve,
  output logic       btn_req,
  output logic       btn_db,
  output logic       tick,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    SERVING = 2'b10
  } req_state_e;

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] DIV_LAST = TICK_W'(TICK_DIV - 1);

  // TP only matters to delay-annotated simulation models; this implementation needs none.
  if (TP < 0) begin : g_tp_unused
  end

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              btn_db_q, btn_db_d;
  logic              btn_db_prev_q, btn_db_prev_d;
  req_state_e        state_q, state_d;
  logic              btn_req_q, btn_req_d;
  logic [7:0]        press_cnt_q, press_cnt_d;
  logic [TICK_W-1:0] div_q, div_d;
  logic              tick_q, tick_d;
  logic              press;

  // Two-flop synchronizer ahead of the debouncer; btn_raw is asynchronous to clk.
  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // Any cycle where s2 agrees with the accepted level restarts the stability count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    deb_cnt_d     = '0;
    btn_db_d      = btn_db_q;
    btn_db_prev_d = btn_db_q;
    if (s2_q != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign press = btn_db_q & ~btn_db_prev_q;

  // serve outranks press; presses while serving are dropped rather than queued.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = SERVING;
        end else if (press) begin
          state_d = PENDING;
          if (press_cnt_q != 8'hFF) press_cnt_d = press_cnt_q + 8'd1;
        end
      end
      PENDING: if (serve)  state_d = SERVING;
      SERVING: if (!serve) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    btn_req_d = (state_d == PENDING);
  end

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d = (div_q == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      deb_cnt_q     <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      state_q       <= IDLE;
      btn_req_q     <= 1'b0;
      press_cnt_q   <= '0;
      div_q         <= '0;
      tick_q        <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      deb_cnt_q     <= deb_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      state_q       <= state_d;
      btn_req_q     <= btn_req_d;
      press_cnt_q   <= press_cnt_d;
      div_q         <= div_d;
      tick_q        <= tick_d;
    end
  end

  assign btn_req   = btn_req_q;
  assign btn_db    = btn_db_q;
  assign tick      = tick_q;
  assign press_cnt = press_cnt_q;

endmodule
